matrix_3_3_mult_ctrl: RTL and testbench

Sequencer/datapath that computes C = A x B for two 3x3 matrices held in clocked ROMs (matrix A ROM and its matrix B twin). It sits directly downstream of the ROMs. It drives their row/col addresses, consumes their 1-cycle-latency read data, and multiply-accumulates the products. It emits each C element with a one-cycle valid strobe, in row-major order.

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_idx_counter.sv | 42 ++++
 rtl/matrix_3_3_mult_ctrl.sv | 116 +++++++++++
 tb/tb_matrix_3_3_mult_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and index helpers for the 3x3 matrix multiply controller.
package matrix_pkg;

    localparam int N    = 3;
    localparam int DW   = 3;
    localparam int ACCW = 8;
    localparam int IDXW = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = S_IDLE,
        RUN   = S_RUN,
        DRAIN = S_DRAIN,
        DONE  = S_DONE
    } state_t;

    function automatic logic is_last(input logic [IDXW-1:0] idx);
        return idx == IDXW'(N - 1);
    endfunction

endpackage

// File: rtl/matrix_idx_counter.sv
// Nested i/j/k index counter: k steps within an element, j/i step per element in row-major order.
module matrix_idx_counter
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            k_inc,
    input  logic            elem_adv,
    output logic [IDXW-1:0] i,
    output logic [IDXW-1:0] j,
    output logic [IDXW-1:0] k,
    output logic            k_last,
    output logic            elem_last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (clr) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (elem_adv) begin
            k <= '0;
            if (is_last(j)) begin
                j <= '0;
                i <= is_last(i) ? '0 : i + 1'b1;
            end else begin
                j <= j + 1'b1;
            end
        end else if (k_inc) begin
            k <= k + 1'b1;
        end
    end

    assign k_last    = is_last(k);
    assign elem_last = is_last(i) && is_last(j);

endmodule

// File: rtl/matrix_3_3_mult_ctrl.sv
// C = A x B sequencer: drives both ROM addresses, accumulates the 1-cycle-late products, emits C row-major.
module matrix_3_3_mult_ctrl
    import matrix_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [IDXW-1:0] a_row,
    output logic [IDXW-1:0] a_col,
    output logic [IDXW-1:0] b_row,
    output logic [IDXW-1:0] b_col,
    input  logic [DW-1:0]   a_data,
    input  logic [DW-1:0]   b_data,
    output logic            c_valid,
    output logic [IDXW-1:0] c_row,
    output logic [IDXW-1:0] c_col,
    output logic [ACCW-1:0] c_data,
    output logic            busy,
    output logic            done
);

    state_t            state;
    state_t            state_nx;
    logic [IDXW-1:0]   i;
    logic [IDXW-1:0]   j;
    logic [IDXW-1:0]   k;
    logic              k_last;
    logic              elem_last;
    logic              ctr_clr;
    logic              k_inc;
    logic              elem_adv;
    logic [ACCW-1:0]   acc;
    logic [2*DW-1:0]   prod;
    logic [ACCW-1:0]   prod_ext;

    matrix_idx_counter u_idx (
        .clk       (clk),
        .rst       (rst),
        .clr       (ctr_clr),
        .k_inc     (k_inc),
        .elem_adv  (elem_adv),
        .i         (i),
        .j         (j),
        .k         (k),
        .k_last    (k_last),
        .elem_last (elem_last)
    );

    assign a_row = i;
    assign a_col = k;
    assign b_row = k;
    assign b_col = j;

    assign prod     = a_data * b_data;
    assign prod_ext = ACCW'(prod);
    assign busy     = (state != IDLE);

    // k holds at N-1 through DRAIN; the ROM data seen in DRAIN is the last product.
    always_comb begin
        state_nx = state;
        ctr_clr  = 1'b0;
        k_inc    = 1'b0;
        elem_adv = 1'b0;
        case (state)
            IDLE: begin
                ctr_clr = 1'b1;
                if (start) state_nx = RUN;
            end
            RUN: begin
                if (k_last) state_nx = DRAIN;
                else        k_inc    = 1'b1;
            end
            DRAIN: begin
                elem_adv = 1'b1;
                state_nx = elem_last ? DONE : RUN;
            end
            DONE: begin
                ctr_clr  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            c_valid <= 1'b0;
            c_row   <= '0;
            c_col   <= '0;
            c_data  <= '0;
            done    <= 1'b0;
        end else begin
            state   <= state_nx;
            c_valid <= 1'b0;
            done    <= (state == DONE);
            case (state)
                IDLE: acc <= '0;
                RUN: begin
                    // Data in the k=0 cycle still belongs to the previous address.
                    if (k != '0) acc <= acc + prod_ext;
                end
                DRAIN: begin
                    c_data  <= acc + prod_ext;
                    c_row   <= i;
                    c_col   <= j;
                    c_valid <= 1'b1;
                    acc     <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_3_3_mult_ctrl.sv
// Self-checking bench for matrix_3_3_mult_ctrl: ROM models, vector table, strobe scoreboard, corner sequences.
module tb_matrix_3_3_mult_ctrl;
    import matrix_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      a_row, a_col, b_row, b_col;
    logic [DW-1:0]   a_data, b_data;
    logic            c_valid;
    logic [1:0]      c_row, c_col;
    logic [ACCW-1:0] c_data;
    logic            busy, done;

    matrix_3_3_mult_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_row   (a_row),
        .a_col   (a_col),
        .b_row   (b_row),
        .b_col   (b_col),
        .a_data  (a_data),
        .b_data  (b_data),
        .c_valid (c_valid),
        .c_row   (c_row),
        .c_col   (c_col),
        .c_data  (c_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] c;
        logic [7:0] d;
    } exp_t;

    typedef struct packed {
        logic [8:0][2:0] a;
        logic [8:0][2:0] b;
        logic [8:0][7:0] c;
    } vec_t;

    logic [DW-1:0] rom_a [9];
    logic [DW-1:0] rom_b [9];
    vec_t          vecs [4];
    exp_t          sbq [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            strobes  = 0;
    int            dones    = 0;

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        a_data <= (a_row < 2'd3 && a_col < 2'd3) ? rom_a[int'(a_row) * 3 + int'(a_col)] : '0;
        b_data <= (b_row < 2'd3 && b_col < 2'd3) ? rom_b[int'(b_row) * 3 + int'(b_col)] : '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done) dones++;
        if (!rst && c_valid) begin
            strobes++;
            if (sbq.size() == 0) begin
                check("unexpected_strobe", {c_row, c_col, c_data}, 32'hFFFF);
            end else begin
                e = sbq.pop_front();
                check("c_out{row,col,data}", {20'h0, c_row, c_col, c_data}, {20'h0, e});
            end
        end
    end

    task automatic load(input int v);
        exp_t e;
        for (int n = 0; n < 9; n++) begin
            rom_a[n] = vecs[v].a[n];
            rom_b[n] = vecs[v].b[n];
        end
        for (int n = 0; n < 9; n++) begin
            e.r = 2'(n / 3);
            e.c = 2'(n % 3);
            e.d = vecs[v].c[n];
            sbq.push_back(e);
        end
    endtask

    task automatic push_exp(input int v);
        exp_t e;
        for (int n = 0; n < 9; n++) begin
            e.r = 2'(n / 3);
            e.c = 2'(n % 3);
            e.d = vecs[v].c[n];
            sbq.push_back(e);
        end
    endtask

    // rel counts edges after the one that samples start; done rises on edge 37 (38th cycle).
    task automatic do_run(input bit spam, input bit addr_chk);
        int c0, rel, first_v, drel, s0, d0;
        s0 = strobes;
        d0 = dones;
        @(negedge clk);
        start   = 1'b1;
        c0      = cyc + 1;
        first_v = -1;
        drel    = -1;
        for (int t = 0; t < 200 && drel < 0; t++) begin
            @(negedge clk);
            rel = cyc - c0;
            start = spam && rel < 30 && (rel % 3 == 0);
            if (rel == 0) check("busy_after_start", 32'(busy), 1);
            if (c_valid && first_v < 0) first_v = rel;
            if (addr_chk && rel >= 20 && rel <= 22)
                check("addr_elem12{ar,ac,br,bc}", {24'h0, a_row, a_col, b_row, b_col},
                      {24'h0, 2'd1, 2'(rel - 20), 2'(rel - 20), 2'd2});
            if (done) drel = rel;
        end
        start = 1'b0;
        check("first_valid_latency", 32'(first_v), 32'd4);
        check("done_latency", 32'(drel), 32'd37);
        check("idle_at_done{busy,addr,c_valid}", {23'h0, busy, a_row, a_col, b_row, b_col, c_valid}, 0);
        repeat (4) @(negedge clk);
        check("strobe_count", 32'(strobes - s0), 32'd9);
        check("done_count", 32'(dones - d0), 32'd1);
        check("scoreboard_empty", 32'(sbq.size()), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int t = 0; t < 200 && at < 0; t++) begin
            @(negedge clk);
            if (done) at = cyc;
        end
        if (at < 0) check("done_timeout", 0, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rel, s0, d0, d1, d2;
        for (int n = 0; n < 9; n++) begin
            vecs[0].a[n] = 3'(n % 3 + 1);
            vecs[0].b[n] = (n / 3 == n % 3) ? 3'd1 : 3'd0;
            vecs[0].c[n] = 8'(n % 3 + 1);
            vecs[1].a[n] = 3'(n % 3 + 1);
            vecs[1].b[n] = 3'(n % 3 + 1);
            vecs[1].c[n] = 8'(6 * (n % 3 + 1));
            vecs[2].a[n] = 3'd7;
            vecs[2].b[n] = 3'd7;
            vecs[2].c[n] = 8'h93;
            vecs[3].a[n] = 3'($urandom_range(7));
            vecs[3].b[n] = 3'($urandom_range(7));
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                vecs[3].c[r * 3 + c] = '0;
                for (int k = 0; k < 3; k++)
                    vecs[3].c[r * 3 + c] += 8'(vecs[3].a[r * 3 + k]) * 8'(vecs[3].b[k * 3 + c]);
            end
        for (int n = 0; n < 9; n++) begin
            rom_a[n] = '0;
            rom_b[n] = '0;
        end

        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {19'h0, c_valid, c_row, c_col, c_data, busy, done}, 0);
        check("reset_addr", {24'h0, a_row, a_col, b_row, b_col}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            load(v);
            do_run(1'b0, v == 0);
        end

        // start pulsed while busy must not restart or add strobes
        load(1);
        do_run(1'b1, 1'b1);

        // asynchronous reset mid-cycle during the 5th element
        load(2);
        s0 = strobes;
        d0 = dones;
        @(negedge clk);
        start = 1'b1;
        c0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        rel = cyc - c0;
        while (rel < 17) begin
            @(negedge clk);
            rel = cyc - c0;
        end
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {19'h0, c_valid, c_row, c_col, c_data, busy, done}, 0);
        check("async_reset_addr", {24'h0, a_row, a_col, b_row, b_col}, 0);
        check("strobes_before_abort", 32'(strobes - s0), 32'd4);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        check("no_done_after_abort", 32'(dones - d0), 0);
        check("no_restart_after_abort", 32'(busy), 0);
        load(2);
        do_run(1'b0, 1'b0);

        // start held high across DONE: back-to-back runs one IDLE cycle apart
        load(1);
        push_exp(1);
        s0 = strobes;
        @(negedge clk);
        start = 1'b1;
        wait_done(d1);
        @(negedge clk);
        check("restart_busy", 32'(busy), 1);
        start = 1'b0;
        wait_done(d2);
        check("back_to_back_spacing", 32'(d2 - d1), 32'd38);
        repeat (4) @(negedge clk);
        check("back_to_back_strobes", 32'(strobes - s0), 32'd18);
        check("back_to_back_sb_empty", 32'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
